// File: rtl/bus_unit_pkg.sv
// Shared definitions for the Unibus-style bus master: state codes,
// timing defaults and byte-lane helpers.
package bus_unit_pkg;

    // Default timing: setup cycles before MSYN, and SSYN wait limit.
    localparam int DESKEW_DEF  = 2;
    localparam int TIMEOUT_DEF = 16;

    // Handshake FSM state encoding.
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_SETUP   = 3'd1;
    localparam state_t S_WAIT    = 3'd2;
    localparam state_t S_RELEASE = 3'd3;
    localparam state_t S_FAULT   = 3'd4;

    // Byte lanes within a 16-bit bus word.
    localparam int LANE_W  = 8;
    localparam int LANE_LO = 0;
    localparam int LANE_HI = 8;

    // Select the addressed byte of a bus word (hi = addr[0]).
    function automatic logic [LANE_W-1:0] byte_lane(input logic [15:0] d, input logic hi);
        return hi ? d[LANE_HI +: LANE_W] : d[LANE_LO +: LANE_W];
    endfunction

    // Replicate a byte onto both lanes so the slave can pick either.
    function automatic logic [15:0] dup_byte(input logic [LANE_W-1:0] b);
        return {b, b};
    endfunction

endpackage

// File: rtl/bus_unit_if.sv
// Unibus-style slave bus: address/data/control from the master,
// SSYN and read data back from the slave.
interface bus_unit_if;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_write;
    logic        bus_byte;
    logic        bus_msyn;
    logic        bus_ssyn;
    logic [15:0] bus_rdata;

    modport master (
        output bus_addr, bus_wdata, bus_write, bus_byte, bus_msyn,
        input  bus_ssyn, bus_rdata
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_write, bus_byte, bus_msyn,
        output bus_ssyn, bus_rdata
    );
endinterface

// File: rtl/bus_unit_sync2.sv
// Two-flop synchroniser for asynchronous slave handshake inputs.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    // Two back-to-back flops; only q is safe to use downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/bus_unit.sv
// Bus master: turns single-cycle datapath memory requests into a fully
// interlocked MSYN/SSYN cycle, flagging odd word addresses and slave
// timeouts as bus errors. Every output is a flop.
module bus_unit
    import bus_unit_pkg::*;
#(
    parameter int DESKEW  = DESKEW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        byte_acc,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    bus_unit_if.master  bus
);
    localparam logic [7:0] SETUP_LAST = 8'(DESKEW - 1);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_t      state_q, state_n;
    logic [7:0]  timer_q, timer_d;
    logic        ssyn_s;

    logic [15:0] baddr_q, baddr_d;
    logic [15:0] bwdata_q, bwdata_d;
    logic        bwrite_q, bwrite_d;
    logic        bbyte_q, bbyte_d;
    logic        msyn_q, msyn_d;
    logic [15:0] rdata_d;
    logic        done_d, err_d, busy_d;

    wire odd_word = !byte_acc && addr[0];
    wire setup_end = (timer_q == SETUP_LAST);
    wire tmo_end   = (timer_q == TMO_LAST);

    sync2 #(.W(1)) u_ssyn_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (bus.bus_ssyn),
        .q     (ssyn_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_n;
    end

    // Next-state: handshake progression, fault and timeout exits.
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:    if (req) state_n = odd_word ? S_FAULT : S_SETUP;
            S_SETUP:   if (setup_end) state_n = S_WAIT;
            S_WAIT:    if (ssyn_s) state_n = S_RELEASE;
                       else if (tmo_end) state_n = S_IDLE;
            S_RELEASE: if (!ssyn_s || tmo_end) state_n = S_IDLE;
            S_FAULT:   state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // Output next-values: bus drive, read capture, completion pulses, timer.
    always_comb begin
        baddr_d  = baddr_q;
        bwdata_d = bwdata_q;
        bwrite_d = bwrite_q;
        bbyte_d  = bbyte_q;
        msyn_d   = msyn_q;
        rdata_d  = rdata;
        timer_d  = timer_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (req && !odd_word) begin
                    baddr_d  = addr;
                    bwrite_d = we;
                    bbyte_d  = byte_acc;
                    if (we) bwdata_d = byte_acc ? dup_byte(wdata[7:0]) : wdata;
                end
            end
            S_SETUP: begin
                if (setup_end) begin
                    msyn_d  = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_WAIT: begin
                if (ssyn_s) begin
                    if (!bwrite_q)
                        rdata_d = bbyte_q ? {8'h00, byte_lane(bus.bus_rdata, baddr_q[0])}
                                          : bus.bus_rdata;
                    msyn_d  = 1'b0;
                    timer_d = '0;
                end else if (tmo_end) begin
                    msyn_d = 1'b0;
                    err_d  = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_RELEASE: begin
                if (!ssyn_s)      done_d = 1'b1;
                else if (tmo_end) err_d  = 1'b1;
                else              timer_d = timer_q + 8'd1;
            end
            S_FAULT: err_d = 1'b1;
            default: ;
        endcase
        // Bus lines idle at zero whenever the FSM heads back to IDLE.
        if (state_q != S_IDLE && state_n == S_IDLE) begin
            baddr_d  = '0;
            bwdata_d = '0;
            bwrite_d = 1'b0;
            bbyte_d  = 1'b0;
            msyn_d   = 1'b0;
        end
        busy_d = (state_n != S_IDLE);
    end

    // Output and timer registers; reset drops MSYN immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baddr_q  <= '0;
            bwdata_q <= '0;
            bwrite_q <= 1'b0;
            bbyte_q  <= 1'b0;
            msyn_q   <= 1'b0;
            rdata    <= '0;
            timer_q  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            baddr_q  <= baddr_d;
            bwdata_q <= bwdata_d;
            bwrite_q <= bwrite_d;
            bbyte_q  <= bbyte_d;
            msyn_q   <= msyn_d;
            rdata    <= rdata_d;
            timer_q  <= timer_d;
            done     <= done_d;
            err      <= err_d;
            busy     <= busy_d;
        end
    end

    assign bus.bus_addr  = baddr_q;
    assign bus.bus_wdata = bwdata_q;
    assign bus.bus_write = bwrite_q;
    assign bus.bus_byte  = bbyte_q;
    assign bus.bus_msyn  = msyn_q;

endmodule
